adbg_spr_resp: RTL and testbench

Core-side responder for the debug SPR bus, sitting inside each core's debug unit. It accepts strobe/write-enable/address/data accesses from the debug interface's per-core SPR port and returns a single-cycle acknowledge. It serves local debug control/status registers itself and forwards GPR/NPC accesses to the core's register port through a request/grant/valid handshake, with a timeout guard.

---
 rtl/adbg_spr_pkg.sv | 31 +++
 rtl/adbg_spr_timeout.sv | 38 +++
 rtl/adbg_spr_resp.sv | 193 +++++++++++++++++++
 tb/tb_adbg_spr_resp.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adbg_spr_pkg.sv
// Shared definitions for the debug SPR responder: address map, DMR/DSR
// bit positions, responder FSM state type and the forwarded-address decode.
package adbg_spr_pkg;

  localparam logic [15:0] ADDR_DMR      = 16'h3000;
  localparam logic [15:0] ADDR_DSR      = 16'h3001;
  localparam logic [15:0] ADDR_NPC      = 16'h3002;
  localparam logic [15:0] ADDR_GPR_BASE = 16'h0400;

  localparam int DMR_HALT      = 0;
  localparam int DMR_STEP_EN   = 1;
  localparam int DMR_RESUME    = 2;
  localparam int DSR_HALTED    = 0;
  localparam int DSR_STEP_DONE = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOCAL,
    ST_CORE_REQ,
    ST_CORE_WAIT,
    ST_ACK
  } spr_state_e;

  // NPC and the GPR window are served by the core, not by this block.
  function automatic logic is_fwd(input logic [15:0] addr, input int unsigned nb_gpr);
    logic [16:0] gpr_end;
    gpr_end = 17'(ADDR_GPR_BASE) + 17'(nb_gpr);
    return (addr == ADDR_NPC) || ((addr >= ADDR_GPR_BASE) && ({1'b0, addr} < gpr_end));
  endfunction

endpackage

// File: rtl/adbg_spr_timeout.sv
// Down-counting guard timer for forwarded core accesses.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : reload counter with TIMEOUT_CYCLES
//   en_i          : count one cycle of waiting
//   expired_o     : high in the last allowed waiting cycle
module adbg_spr_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 16'(TIMEOUT_CYCLES);
    end else if (en_i && (cnt_q != 16'd0)) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count of 1: the counter was loaded with N, so this is wait cycle N.
  assign expired_o = en_i && (cnt_q == 16'd1);

endmodule

// File: rtl/adbg_spr_resp.sv
// Core-side debug SPR responder. Serves DMR/DSR locally, forwards NPC/GPR
// accesses to the core register port (req/gnt/rvalid) with a timeout.
//   spr_*        : debug-side access port (stb held until one-cycle ack)
//   core_*       : forwarded-access port to the core
//   core_halted_i: core halt status
//   halt_req_o / step_o / resume_o : run control to the core
//
// state        | meaning
// -------------|-----------------------------------------------------
// ST_IDLE      | waiting for a strobe (ignored in the cycle after ack)
// ST_LOCAL     | DMR/DSR/unmapped/refused access, ack this cycle
// ST_CORE_REQ  | core_req_o high, waiting for grant
// ST_CORE_WAIT | granted, waiting for rvalid
// ST_ACK       | forwarded access done (or timed out), ack this cycle
module adbg_spr_resp
  import adbg_spr_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned NB_GPR         = 32
) (
  input  logic        cpu_clk_i,
  input  logic        cpu_rstn_i,
  input  logic [15:0] spr_addr_i,
  input  logic [31:0] spr_data_i,
  output logic [31:0] spr_data_o,
  input  logic        spr_stb_i,
  input  logic        spr_we_i,
  output logic        spr_ack_o,
  output logic        core_req_o,
  output logic        core_we_o,
  output logic [15:0] core_addr_o,
  output logic [31:0] core_wdata_o,
  input  logic        core_gnt_i,
  input  logic        core_rvalid_i,
  input  logic [31:0] core_rdata_i,
  input  logic        core_halted_i,
  output logic        halt_req_o,
  output logic        step_o,
  output logic        resume_o
);

  spr_state_e  state_q, state_d;
  logic        ack_dly_q;
  logic [31:0] data_q, data_d;
  logic        core_we_q, core_we_d;
  logic [15:0] core_addr_q, core_addr_d;
  logic [31:0] core_wdata_q, core_wdata_d;
  logic [1:0]  dmr_q, dmr_d;
  logic        step_done_q, step_done_d;
  logic        halted_q;
  logic        step_q, step_d, resume_q, resume_d;
  logic        to_load, to_en, to_expired;
  logic        stb_ok, wr_dmr, wr_dsr, halt_rise;
  logic [31:0] local_rdata;

  adbg_spr_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i     (cpu_clk_i),
    .rst_ni    (cpu_rstn_i),
    .load_i    (to_load),
    .en_i      (to_en),
    .expired_o (to_expired)
  );

  assign stb_ok    = spr_stb_i && !ack_dly_q;
  assign wr_dmr    = (state_q == ST_LOCAL) && spr_we_i && (spr_addr_i == ADDR_DMR);
  assign wr_dsr    = (state_q == ST_LOCAL) && spr_we_i && (spr_addr_i == ADDR_DSR);
  assign halt_rise = core_halted_i && !halted_q;

  // Read value is captured while leaving IDLE so it is registered during ack.
  always_comb begin
    local_rdata = '0;
    if (!spr_we_i) begin
      if (spr_addr_i == ADDR_DMR) begin
        local_rdata[1:0] = dmr_q;
      end else if (spr_addr_i == ADDR_DSR) begin
        local_rdata[DSR_HALTED]    = core_halted_i;
        local_rdata[DSR_STEP_DONE] = step_done_q;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    core_we_d    = core_we_q;
    core_addr_d  = core_addr_q;
    core_wdata_d = core_wdata_q;
    to_load      = 1'b0;
    to_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stb_ok) begin
          to_load = 1'b1;
          if (is_fwd(spr_addr_i, NB_GPR) && core_halted_i) begin
            state_d      = ST_CORE_REQ;
            core_we_d    = spr_we_i;
            core_addr_d  = spr_addr_i;
            core_wdata_d = spr_data_i;
          end else begin
            state_d = ST_LOCAL;
            data_d  = local_rdata;
          end
        end
      end
      ST_LOCAL: state_d = ST_IDLE;
      ST_CORE_REQ: begin
        to_en = 1'b1;
        if (core_gnt_i && core_rvalid_i) begin
          state_d = ST_ACK;
          data_d  = core_we_q ? 32'd0 : core_rdata_i;
        end else if (to_expired) begin
          state_d = ST_ACK;
          data_d  = '0;
        end else if (core_gnt_i) begin
          state_d = ST_CORE_WAIT;
        end
      end
      ST_CORE_WAIT: begin
        to_en = 1'b1;
        if (core_rvalid_i) begin
          state_d = ST_ACK;
          data_d  = core_we_q ? 32'd0 : core_rdata_i;
        end else if (to_expired) begin
          state_d = ST_ACK;
          data_d  = '0;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dmr_d       = dmr_q;
    step_d      = 1'b0;
    resume_d    = 1'b0;
    step_done_d = step_done_q;
    if (wr_dmr) begin
      dmr_d[DMR_STEP_EN] = spr_data_i[DMR_STEP_EN];
      // A resume releases the core, so the halt request is dropped with it.
      dmr_d[DMR_HALT]    = spr_data_i[DMR_HALT] && !spr_data_i[DMR_RESUME];
      if (spr_data_i[DMR_RESUME]) begin
        step_d   = spr_data_i[DMR_STEP_EN];
        resume_d = !spr_data_i[DMR_STEP_EN];
      end
    end
    if (wr_dsr && spr_data_i[DSR_STEP_DONE]) begin
      step_done_d = 1'b0;
    end
    if (halt_rise && dmr_q[DMR_STEP_EN]) begin
      step_done_d = 1'b1;
    end
  end

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) begin
      state_q      <= ST_IDLE;
      ack_dly_q    <= 1'b0;
      data_q       <= '0;
      core_we_q    <= 1'b0;
      core_addr_q  <= '0;
      core_wdata_q <= '0;
      dmr_q        <= '0;
      step_done_q  <= 1'b0;
      halted_q     <= 1'b0;
      step_q       <= 1'b0;
      resume_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ack_dly_q    <= spr_ack_o;
      data_q       <= data_d;
      core_we_q    <= core_we_d;
      core_addr_q  <= core_addr_d;
      core_wdata_q <= core_wdata_d;
      dmr_q        <= dmr_d;
      step_done_q  <= step_done_d;
      halted_q     <= core_halted_i;
      step_q       <= step_d;
      resume_q     <= resume_d;
    end
  end

  assign spr_ack_o    = (state_q == ST_LOCAL) || (state_q == ST_ACK);
  assign spr_data_o   = data_q;
  assign core_req_o   = (state_q == ST_CORE_REQ);
  assign core_we_o    = core_we_q;
  assign core_addr_o  = core_addr_q;
  assign core_wdata_o = core_wdata_q;
  assign halt_req_o   = dmr_q[DMR_HALT];
  assign step_o       = step_q;
  assign resume_o     = resume_q;

endmodule

// File: tb/tb_adbg_spr_resp.sv
module tb_adbg_spr_resp;

  localparam int TO = 8;

  logic        cpu_clk_i = 1'b0;
  logic        cpu_rstn_i;
  logic [15:0] spr_addr_i;
  logic [31:0] spr_data_i;
  logic [31:0] spr_data_o;
  logic        spr_stb_i;
  logic        spr_we_i;
  logic        spr_ack_o;
  logic        core_req_o;
  logic        core_we_o;
  logic [15:0] core_addr_o;
  logic [31:0] core_wdata_o;
  logic        core_gnt_i;
  logic        core_rvalid_i;
  logic [31:0] core_rdata_i;
  logic        core_halted_i;
  logic        halt_req_o;
  logic        step_o;
  logic        resume_o;

  adbg_spr_resp #(.TIMEOUT_CYCLES(TO), .NB_GPR(32)) dut (
    .cpu_clk_i     (cpu_clk_i),
    .cpu_rstn_i    (cpu_rstn_i),
    .spr_addr_i    (spr_addr_i),
    .spr_data_i    (spr_data_i),
    .spr_data_o    (spr_data_o),
    .spr_stb_i     (spr_stb_i),
    .spr_we_i      (spr_we_i),
    .spr_ack_o     (spr_ack_o),
    .core_req_o    (core_req_o),
    .core_we_o     (core_we_o),
    .core_addr_o   (core_addr_o),
    .core_wdata_o  (core_wdata_o),
    .core_gnt_i    (core_gnt_i),
    .core_rvalid_i (core_rvalid_i),
    .core_rdata_i  (core_rdata_i),
    .core_halted_i (core_halted_i),
    .halt_req_o    (halt_req_o),
    .step_o        (step_o),
    .resume_o      (resume_o)
  );

  always #5 cpu_clk_i = ~cpu_clk_i;

  int cmp_cnt = 0, err_cnt = 0;
  int ack_total = 0, exp_acks = 0;
  int step_hi = 0, resume_hi = 0, exp_step = 0, exp_resume = 0;
  logic [31:0] exp_q[$];
  logic [31:0] core_mem[33];
  logic [31:0] ref_mem[33];
  bit  core_resp_en = 1'b1;
  int  gnt_dly = 0, rv_dly = 0;
  int  poke_cnt = 0;
  bit  m_halt = 0, m_step_en = 0, m_step_done = 0, m_halted = 0;
  bit  prev_ack = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [15:0] a);
    if (a == 16'h3002) return 32;
    if (a >= 16'h0400 && a < 16'h0420) return int'(a - 16'h0400);
    return 0;
  endfunction

  function automatic bit mapped(input logic [15:0] a);
    return (a == 16'h3000) || (a == 16'h3001) || (a == 16'h3002) || (a >= 16'h0400 && a < 16'h0420);
  endfunction

  // Scoreboard monitor: every ack must match the oldest outstanding expectation.
  always @(negedge cpu_clk_i) begin
    if (step_o) step_hi++;
    if (resume_o) resume_hi++;
    if (spr_ack_o) begin
      ack_total++;
      check("ack_not_back_to_back", {31'b0, prev_ack}, 32'd0);
      if (exp_q.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL spurious_ack: data 0x%08h with nothing outstanding", spr_data_o);
      end else begin
        check("ack_data", spr_data_o, exp_q.pop_front());
      end
    end
    prev_ack = spr_ack_o;
  end

  // Behavioural core register port.
  initial begin : core_model
    int poke_seen;
    int idx;
    logic w;
    logic [31:0] d;
    poke_seen = 0;
    core_gnt_i = 1'b0; core_rvalid_i = 1'b0; core_rdata_i = '0;
    forever begin
      @(posedge cpu_clk_i); #1;
      if (core_req_o && core_resp_en) begin
        idx = idx_of(core_addr_o); w = core_we_o; d = core_wdata_o;
        repeat (gnt_dly) begin @(posedge cpu_clk_i); #1; end
        core_gnt_i = 1'b1;
        if (rv_dly == 0) begin
          core_rvalid_i = 1'b1;
          core_rdata_i  = w ? $urandom : core_mem[idx];
          if (w) core_mem[idx] = d;
        end
        @(posedge cpu_clk_i); #1;
        core_gnt_i = 1'b0; core_rvalid_i = 1'b0;
        if (rv_dly > 0) begin
          repeat (rv_dly - 1) begin @(posedge cpu_clk_i); #1; end
          core_rvalid_i = 1'b1;
          core_rdata_i  = w ? $urandom : core_mem[idx];
          if (w) core_mem[idx] = d;
          @(posedge cpu_clk_i); #1;
          core_rvalid_i = 1'b0;
        end
      end else if (poke_cnt != poke_seen) begin
        poke_seen = poke_cnt;
        core_rvalid_i = 1'b1; core_rdata_i = 32'hDEADBEEF;
        @(posedge cpu_clk_i); #1;
        core_rvalid_i = 1'b0;
      end
    end
  end

  task automatic do_access(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp, input int exp_lat, input bit hold);
    int n;
    bit got, saw_req;
    exp_q.push_back(exp);
    exp_acks++;
    @(posedge cpu_clk_i); #1;
    spr_stb_i = 1'b1; spr_we_i = we; spr_addr_i = addr; spr_data_i = wd;
    n = 0; got = 0; saw_req = 0;
    while (!got && n < 200) begin
      @(negedge cpu_clk_i);
      n++;
      if (core_req_o) saw_req = 1;
      if (spr_ack_o) got = 1;
    end
    @(posedge cpu_clk_i); #1;
    if (hold) begin @(posedge cpu_clk_i); #1; end
    spr_stb_i = 1'b0;
    check("ack_seen", {31'b0, got}, 32'd1);
    if (!got && exp_q.size() > 0) void'(exp_q.pop_back());
    if (exp_lat > 0) check("ack_latency", n, exp_lat);
    if (exp_lat == 2) check("no_core_req", {31'b0, saw_req}, 32'd0);
  endtask

  task automatic access(input logic we, input logic [15:0] addr, input logic [31:0] wd, input bit hold);
    logic [31:0] e;
    int lat;
    e = '0; lat = 2;
    if ((addr == 16'h3002 || (addr >= 16'h0400 && addr < 16'h0420)) && m_halted) begin
      lat = 0;
      if (we) ref_mem[idx_of(addr)] = wd;
      else e = ref_mem[idx_of(addr)];
    end else if (addr == 16'h3000) begin
      if (we) begin
        if (wd[2]) begin
          if (wd[1]) exp_step++;
          else exp_resume++;
        end
        m_step_en = wd[1];
        m_halt    = wd[0] && !wd[2];
      end else begin
        e = {30'b0, m_step_en, m_halt};
      end
    end else if (addr == 16'h3001) begin
      if (we) begin
        if (wd[1]) m_step_done = 0;
      end else begin
        e = {30'b0, m_step_done, m_halted};
      end
    end
    do_access(we, addr, wd, e, lat, hold);
    check("halt_req", {31'b0, halt_req_o}, {31'b0, m_halt});
  endtask

  task automatic set_halted(input bit v);
    @(posedge cpu_clk_i); #1;
    if (v && !m_halted && m_step_en) m_step_done = 1;
    m_halted = v;
    core_halted_i = v;
    repeat (2) @(posedge cpu_clk_i);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, {26'b0, spr_ack_o, core_req_o, core_we_o, halt_req_o, step_o, resume_o}, 32'd0);
    check({tag, "_rdata"}, spr_data_o, 32'd0);
    check({tag, "_core_bus"}, {16'b0, core_addr_o} | core_wdata_o, 32'd0);
  endtask

  initial begin : stim
    int s0, r0, n, k;
    logic [15:0] a;
    logic [31:0] wd;
    logic we;
    for (int i = 0; i < 33; i++) begin
      core_mem[i] = $urandom;
      ref_mem[i]  = core_mem[i];
    end
    core_mem[5] = 32'hCAFE0005;
    ref_mem[5]  = 32'hCAFE0005;
    cpu_rstn_i = 1'b0; spr_stb_i = 1'b0; spr_we_i = 1'b0; spr_addr_i = '0; spr_data_i = '0;
    core_halted_i = 1'b0;
    repeat (3) @(posedge cpu_clk_i); #1;
    check_outputs_zero("reset");
    cpu_rstn_i = 1'b1;
    repeat (2) @(posedge cpu_clk_i);

    // DMR halt request write then read back
    access(1'b1, 16'h3000, 32'h1, 1'b0);
    access(1'b0, 16'h3000, 32'h0, 1'b0);

    // Forwarded read, grant after 3 cycles, rvalid 2 later
    set_halted(1);
    gnt_dly = 3; rv_dly = 2;
    access(1'b0, 16'h0405, 32'h0, 1'b0);
    check("core_addr", {16'b0, core_addr_o}, 32'h0405);

    // Forwarded write refused while core running
    set_halted(0);
    access(1'b1, 16'h0402, 32'h1234, 1'b1);

    // Timeout with no grant, then a late rvalid must not ack
    set_halted(1);
    core_resp_en = 1'b0;
    do_access(1'b0, 16'h0407, 32'h0, 32'h0, TO + 2, 1'b0);
    check("req_dropped_on_timeout", {31'b0, core_req_o}, 32'd0);
    poke_cnt++;
    repeat (6) @(posedge cpu_clk_i);
    core_resp_en = 1'b1;

    // Single step and step_done W1C
    set_halted(0);
    access(1'b1, 16'h3000, 32'h2, 1'b0);
    s0 = step_hi; r0 = resume_hi;
    access(1'b1, 16'h3000, 32'h6, 1'b0);
    repeat (3) @(posedge cpu_clk_i);
    check("step_pulse", step_hi - s0, 1);
    check("no_resume_on_step", resume_hi - r0, 0);
    set_halted(1);
    access(1'b0, 16'h3001, 32'h0, 1'b0);
    access(1'b1, 16'h3001, 32'h2, 1'b0);
    access(1'b0, 16'h3001, 32'h0, 1'b0);

    // Randomized mix against the reference model
    for (int i = 0; i < 60; i++) begin
      k  = $urandom_range(0, 9);
      wd = $urandom;
      we = 1'($urandom_range(0, 1));
      gnt_dly = $urandom_range(0, 3);
      rv_dly  = $urandom_range(0, 2);
      if ($urandom_range(0, 4) == 0) set_halted(!m_halted);
      case (k)
        0, 1:    a = 16'h3000;
        2, 3:    a = 16'h3001;
        4, 5, 6: a = 16'h0400 + 16'($urandom_range(0, 31));
        7:       a = 16'h3002;
        default: begin
          a = 16'($urandom);
          while (mapped(a)) a = 16'($urandom);
        end
      endcase
      access(we, a, wd, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a forwarded access
    set_halted(1);
    access(1'b1, 16'h3000, 32'h1, 1'b0);
    access(1'b0, 16'h3000, 32'h0, 1'b0);
    gnt_dly = 0; rv_dly = 20;
    @(posedge cpu_clk_i); #1;
    spr_stb_i = 1'b1; spr_we_i = 1'b0; spr_addr_i = 16'h0403; spr_data_i = '0;
    n = 0;
    while (!core_req_o && n < 20) begin @(negedge cpu_clk_i); n++; end
    while (core_req_o && n < 40) begin @(negedge cpu_clk_i); n++; end
    check("reach_core_wait", {31'b0, (n < 40)}, 32'd1);
    @(posedge cpu_clk_i); #1;
    cpu_rstn_i = 1'b0; spr_stb_i = 1'b0;
    m_halt = 0; m_step_en = 0; m_step_done = 0;
    #1;
    check_outputs_zero("mid_reset");
    repeat (2) @(posedge cpu_clk_i); #1;
    cpu_rstn_i = 1'b1;
    repeat (30) @(posedge cpu_clk_i);
    check("no_ack_after_reset", ack_total, exp_acks);
    gnt_dly = 1; rv_dly = 1;
    access(1'b0, 16'h0403, 32'h0, 1'b0);
    access(1'b0, 16'h3000, 32'h0, 1'b0);

    repeat (4) @(posedge cpu_clk_i);
    check("total_acks", ack_total, exp_acks);
    check("total_step_pulses", step_hi, exp_step);
    check("total_resume_pulses", resume_hi, exp_resume);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
